uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART 8N1 serial transmitter.
- Sits directly downstream of the UART CSR block. It consumes the CSR data byte and the one-cycle START pulse.
- It returns READY and TX_DONE status levels, which the CSR block samples every cycle.
- Drives the chip-level TX pin.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200). Legal range is 2 or more.
- CNT_W, $clog2(CLKS_PER_BIT): width of the baud counter. Derived; do not override.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset. Synchronous, active-high.
- data_in  input  8  byte to transmit. Sampled only when start is accepted.
- start  input  1  transmit request. Single-cycle pulse from the CSR block; a held level is also tolerated.
- ready  output  1  high when idle and able to accept start.
- tx_done  output  1  sticky level: the last frame has completed.
- tx  output  1  serial line. Idles high.

Behaviour:
- There is one clock domain. rst is synchronous and active-high.
- Reset values:
  - tx=1, ready=1, tx_done=0.
  - State is IDLE; the baud counter and bit index are 0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE:
  - Drives ready=1 and tx=1.
  - If start=1 in cycle N, the shift register loads data_in in cycle N.
  - At cycle N+1: state=START_BIT, tx=0, ready=0, tx_done=0, and the counter is cleared.
- Bit timing:
  - Each state other than IDLE holds for exactly CLKS_PER_BIT cycles.
  - The counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on each state or bit advance.
- START_BIT: at counter end, go to DATA_BITS with bit index 0. tx = shift[0].
- DATA_BITS:
  - Sends LSB first.
  - At counter end, if bit index < 7: shift right, index+1, tx = next bit.
  - If bit index = 7: go to STOP_BIT with tx=1.
- STOP_BIT: at counter end, go to IDLE, set ready=1 and tx_done=1 in the same cycle.
- Frame length: 10*CLKS_PER_BIT cycles, measured from the first tx=0 cycle to the cycle ready returns high.
- tx_done:
  - Holds at 1 until the next accepted start.
  - Clears in the cycle after that start.
  - Is not cleared by idle time. The CSR read-clear is local to the CSR block.
- Start while busy (state != IDLE):
  - Ignored; it is not queued.
  - data_in changes during a frame have no effect.
- Start in the first IDLE cycle after STOP_BIT is accepted (back-to-back frames). tx_done is high for exactly that one cycle.
- Start held high continuously: the block transmits data_in repeatedly. Each frame is followed by exactly one IDLE cycle.
- Reset mid-frame:
  - Next cycle tx=1, ready=1, tx_done=0, state=IDLE.
  - The partial frame is abandoned.
- Counter arithmetic: unsigned, CNT_W bits. The terminal compare is against CLKS_PER_BIT-1. There is no overflow path.

Decomposition:
- Shared package uart_pkg contains:
  - the tx state enum (IDLE, START_BIT, DATA_BITS, STOP_BIT);
  - UART_DATA_BITS=8;
  - the default baud constant, CLKS_PER_BIT_115200=868.
- One optional sub-module, uart_baud_cnt: a counter with clear input and terminal-count output, reusable by a future uart_rx.
- Everything else lives in one module.

Test Plan:
- Reset, then idle for 50 cycles -> tx=1, ready=1, tx_done=0 throughout.
- CLKS_PER_BIT=4, data_in=8'hA5, start pulse at cycle N:
  - tx low over N+1..N+4;
  - then bits 1,0,1,0,0,1,0,1, each 4 cycles;
  - stop high;
  - ready=1 and tx_done=1 at N+41.
- Start pulse with data_in=8'h3C, then start pulses and data_in=8'hFF during the frame -> a single frame of 8'h3C only; ready stays 0 until the frame ends.
- Start held high, data_in=8'h55:
  - consecutive frames, each separated by exactly one IDLE cycle;
  - tx_done high exactly 1 cycle between frames.
- Assert rst during DATA_BITS bit 3 -> next cycle tx=1, ready=1, tx_done=0. A new start afterwards produces a clean full frame.
- Random bytes at CLKS_PER_BIT=2 and 868 -> a serial monitor decodes each byte exactly. Frame length is 10*CLKS_PER_BIT.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and framing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } tx_state_e;

  localparam int UART_DATA_BITS      = 8;
  localparam int CLKS_PER_BIT_115200 = 868;

endpackage : uart_pkg

// File: rtl/uart_baud_cnt.sv
// Baud-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST);

endmodule : uart_baud_cnt

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. Accepts a byte on start while idle and shifts it out LSB first;
// ready and tx_done are registered status levels for the CSR block.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       start,
  output logic       ready,
  output logic       tx_done,
  output logic       tx
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       tx_q, tx_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       bit_end;

  // Counter is held at zero while idle so every frame starts on a fresh bit period.
  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q == IDLE),
    .en  (state_q != IDLE),
    .tc  (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    done_d    = done_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        tx_d    = 1'b1;
        if (start) begin
          shift_d   = data_in;
          bit_idx_d = '0;
          state_d   = START_BIT;
          tx_d      = 1'b0;
          ready_d   = 1'b0;
          done_d    = 1'b0;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          state_d   = DATA_BITS;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          if (bit_idx_q < LAST_BIT) begin
            // The next serial bit is what lands in shift[0] after this shift.
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end else begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign tx      = tx_q;
  assign ready   = ready_q;
  assign tx_done = done_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT = 4 (main), 2 and 868 (serial decode).
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a [3];
  logic [7:0] data_a  [3];
  logic       tx_a    [3];
  logic       ready_a [3];
  logic       done_a  [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .data_in(data_a[0]), .start(start_a[0]),
    .ready(ready_a[0]), .tx_done(done_a[0]), .tx(tx_a[0]));

  uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(data_a[1]), .start(start_a[1]),
    .ready(ready_a[1]), .tx_done(done_a[1]), .tx(tx_a[1]));

  uart_tx #(.CLKS_PER_BIT(868)) u_dut868 (
    .clk(clk), .rst(rst), .data_in(data_a[2]), .start(start_a[2]),
    .ready(ready_a[2]), .tx_done(done_a[2]), .tx(tx_a[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int sel, input logic exp_done, input string tag);
    chk({tag, ".tx"}, 32'(tx_a[sel]), 32'd1);
    chk({tag, ".ready"}, 32'(ready_a[sel]), 32'd1);
    chk({tag, ".done"}, 32'(done_a[sel]), 32'(exp_done));
  endtask

  // Expected line level of a CPB=4 frame, i cycles after the first start-bit cycle.
  function automatic logic exp_bit4(input logic [7:0] b, input int i);
    if (i < 4)  return 1'b0;
    if (i < 36) return b[(i - 4) / 4];
    return 1'b1;
  endfunction

  // Called in the first start-bit cycle; returns in the cycle ready comes back.
  task automatic check_frame4(input logic [7:0] b, input string tag);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("%s.tx[%0d]", tag, i), 32'(tx_a[0]), 32'(exp_bit4(b, i)));
      chk($sformatf("%s.ready[%0d]", tag, i), 32'(ready_a[0]), 32'd0);
      chk($sformatf("%s.done[%0d]", tag, i), 32'(done_a[0]), 32'd0);
      tick();
    end
    chk_idle(0, 1'b1, {tag, ".end"});
  endtask

  // Pulse start on DUT sel, then decode the serial line by mid-bit sampling.
  task automatic rx_frame(input int sel, input int cpb, input logic [7:0] b);
    logic [9:0] bits;
    int w;
    int c;
    bits = '0;
    data_a[sel]  = b;
    start_a[sel] = 1'b1;
    tick();
    start_a[sel] = 1'b0;
    w = 0;
    while (tx_a[sel] !== 1'b0 && w < 20) begin
      tick();
      w++;
    end
    chk($sformatf("rx%0d.start_seen", cpb), 32'(w < 20), 32'd1);
    c = 0;
    while (ready_a[sel] !== 1'b1 && c < 10 * cpb + 10) begin
      if (c % cpb == cpb / 2) bits[c / cpb] = tx_a[sel];
      tick();
      c++;
    end
    chk($sformatf("rx%0d.len", cpb), 32'(c), 32'(10 * cpb));
    chk($sformatf("rx%0d.startbit", cpb), 32'(bits[0]), 32'd0);
    chk($sformatf("rx%0d.byte", cpb), 32'(bits[8:1]), 32'(b));
    chk($sformatf("rx%0d.stopbit", cpb), 32'(bits[9]), 32'd1);
    chk($sformatf("rx%0d.done", cpb), 32'(done_a[sel]), 32'd1);
  endtask

  initial begin
    logic [7:0] rb;
    for (int s = 0; s < 3; s++) begin
      start_a[s] = 1'b0;
      data_a[s]  = 8'h00;
    end

    // Reset and idle
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) chk_idle(s, 1'b0, $sformatf("reset%0d", s));
    for (int i = 0; i < 50; i++) begin
      tick();
      chk_idle(0, 1'b0, $sformatf("idle[%0d]", i));
    end

    // Single frame of A5
    data_a[0]  = 8'hA5;
    start_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0;
    check_frame4(8'hA5, "a5");
    repeat (5) tick();
    chk_idle(0, 1'b1, "a5.sticky");

    // 3C with start pulses and data changes while busy
    data_a[0]  = 8'h3C;
    start_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("busy.tx[%0d]", i), 32'(tx_a[0]), 32'(exp_bit4(8'h3C, i)));
      chk($sformatf("busy.ready[%0d]", i), 32'(ready_a[0]), 32'd0);
      if (i == 5 || i == 13 || i == 22 || i == 38) begin
        start_a[0] = 1'b1;
        data_a[0]  = 8'hFF;
      end else begin
        start_a[0] = 1'b0;
      end
      tick();
    end
    start_a[0] = 1'b0;
    chk_idle(0, 1'b1, "busy.end");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle(0, 1'b1, $sformatf("busy.noqueue[%0d]", i));
    end

    // Start held high: back-to-back frames of 55
    data_a[0]  = 8'h55;
    start_a[0] = 1'b1;
    tick();
    check_frame4(8'h55, "held1");
    tick();
    start_a[0] = 1'b0;
    check_frame4(8'h55, "held2");
    tick();
    chk_idle(0, 1'b1, "held.after");

    // Reset during data bit 3 of C3, then a clean frame of 96
    data_a[0]  = 8'hC3;
    start_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("rstmid.tx[%0d]", i), 32'(tx_a[0]), 32'(exp_bit4(8'hC3, i)));
      tick();
    end
    chk("rstmid.bit3", 32'(tx_a[0]), 32'd0);
    chk("rstmid.ready_busy", 32'(ready_a[0]), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle(0, 1'b0, "rstmid.after");
    tick();
    chk_idle(0, 1'b0, "rstmid.after2");
    data_a[0]  = 8'h96;
    start_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0;
    check_frame4(8'h96, "post_rst");

    // Random bytes through the serial decoder
    for (int k = 0; k < 8; k++) begin
      rb = 8'($urandom_range(0, 255));
      rx_frame(1, 2, rb);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      rb = 8'($urandom_range(0, 255));
      rx_frame(2, 868, rb);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_uart_tx
